mem_arbiter: RTL and testbench

- Two-port arbiter that shares the single unified memory system (cache plus controller plus four-bank memory) between the fetch port (I) and the load/store port (D).
- Sits between the fetch/memory pipeline stages and the memory system instance.
- Serialises requests, routes address/data/done/stall, applies round-robin fairness and a hang timeout, and keeps per-port hit counters.

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch I / load-store D) arbiter in front of the unified memory system.
// Serialises accesses with round-robin tie-break, watchdogs hung accesses and counts per-port hits.
module mem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rd,
    input  logic [15:0] i_addr,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_data_in,
    output logic [15:0] i_data_out,
    output logic        i_done,
    output logic        i_stall,
    output logic [15:0] d_data_out,
    output logic        d_done,
    output logic        d_stall,
    output logic [15:0] m_addr,
    output logic [15:0] m_data_in,
    output logic        m_rd,
    output logic        m_wr,
    input  logic [15:0] m_data_out,
    input  logic        m_done,
    input  logic        m_stall,
    input  logic        m_cache_hit,
    input  logic        m_err,
    output logic [15:0] i_hits,
    output logic [15:0] d_hits,
    output logic        err,
    output logic [1:0]  state
);

    // Handshake: a requester raises x_rd/x_wr and holds it with stable address/data
    // until x_done pulses for one cycle; x_stall is high for every cycle in between.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t      cur;
    logic        last_d;
    logic [7:0]  tcount;
    logic [15:0] lat_addr;
    logic [15:0] lat_data;

    logic i_req, d_req, idle_st, busy_i, busy_d, win_i, win_d;

    // m_stall is informational only; completion is tracked solely through m_done.
    logic unused_m_stall;
    assign unused_m_stall = m_stall;

    assign state   = cur;
    assign i_req   = i_rd;
    assign d_req   = d_rd | d_wr;
    assign idle_st = (cur == IDLE);
    assign busy_i  = (cur == BUSY_I);
    assign busy_d  = (cur == BUSY_D);
    // On a tie the port that did not win last time gets the grant.
    assign win_d   = idle_st & d_req & (~i_req | ~last_d);
    assign win_i   = idle_st & i_req & ~win_d;

    always_comb begin
        m_addr     = 16'h0000;
        m_data_in  = 16'h0000;
        m_rd       = 1'b0;
        m_wr       = 1'b0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        i_data_out = 16'h0000;
        d_data_out = 16'h0000;
        i_stall    = 1'b0;
        d_stall    = 1'b0;
        if (rst) begin
            if (win_d) begin
                m_addr    = d_addr;
                m_data_in = d_data_in;
                m_rd      = d_rd;
                m_wr      = d_wr;
            end else if (win_i) begin
                m_addr = i_addr;
                m_rd   = 1'b1;
            end else if (busy_d) begin
                m_addr    = lat_addr;
                m_data_in = lat_data;
            end else if (busy_i) begin
                m_addr = lat_addr;
            end
            i_done     = m_done & (win_i | busy_i);
            d_done     = m_done & (win_d | busy_d);
            i_data_out = i_done ? m_data_out : 16'h0000;
            d_data_out = d_done ? m_data_out : 16'h0000;
            i_stall    = i_req & ~i_done;
            d_stall    = d_req & ~d_done;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur      <= IDLE;
            last_d   <= 1'b0;
            tcount   <= 8'd0;
            lat_addr <= 16'h0000;
            lat_data <= 16'h0000;
            i_hits   <= 16'h0000;
            d_hits   <= 16'h0000;
            err      <= 1'b0;
        end else begin
            if (m_err || (d_rd && d_wr))
                err <= 1'b1;
            if (i_done && m_cache_hit && (i_hits != 16'hFFFF))
                i_hits <= i_hits + 16'd1;
            if (d_done && m_cache_hit && (d_hits != 16'hFFFF))
                d_hits <= d_hits + 16'd1;

            case (cur)
                IDLE: begin
                    tcount <= 8'd0;
                    if (win_i || win_d) begin
                        last_d   <= win_d;
                        lat_addr <= win_d ? d_addr : i_addr;
                        lat_data <= win_d ? d_data_in : 16'h0000;
                        if (!m_done) begin
                            cur <= win_d ? BUSY_D : BUSY_I;
                            // The grant cycle itself counts as the first cycle waited.
                            tcount <= 8'd1;
                            if (TMO == 8'd1)
                                err <= 1'b1;
                        end
                    end else if (m_done) begin
                        err <= 1'b1;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (m_done) begin
                        cur    <= IDLE;
                        tcount <= 8'd0;
                    end else begin
                        if (tcount != 8'hFF)
                            tcount <= tcount + 8'd1;
                        if ((tcount + 8'd1) == TMO)
                            err <= 1'b1;
                    end
                end
                default: begin
                    cur    <= IDLE;
                    tcount <= 8'd0;
                    err    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays the memory system and
// checks completions against an expected queue of {port, data} entries.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_rd;
    logic [15:0] i_addr;
    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_data_in;
    logic [15:0] i_data_out;
    logic        i_done;
    logic        i_stall;
    logic [15:0] d_data_out;
    logic        d_done;
    logic        d_stall;
    logic [15:0] m_addr;
    logic [15:0] m_data_in;
    logic        m_rd;
    logic        m_wr;
    logic [15:0] m_data_out;
    logic        m_done;
    logic        m_stall;
    logic        m_cache_hit;
    logic        m_err;
    logic [15:0] i_hits;
    logic [15:0] d_hits;
    logic        err;
    logic [1:0]  state;

    int vectors = 0;
    int miscompares = 0;
    logic mon_en = 1'b1;
    // Entry = {port (1 = D), data_out}
    logic [16:0] exp_q[$];

    mem_arbiter #(.TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .i_rd(i_rd), .i_addr(i_addr),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_data_in(d_data_in),
        .i_data_out(i_data_out), .i_done(i_done), .i_stall(i_stall),
        .d_data_out(d_data_out), .d_done(d_done), .d_stall(d_stall),
        .m_addr(m_addr), .m_data_in(m_data_in), .m_rd(m_rd), .m_wr(m_wr),
        .m_data_out(m_data_out), .m_done(m_done), .m_stall(m_stall),
        .m_cache_hit(m_cache_hit), .m_err(m_err),
        .i_hits(i_hits), .d_hits(d_hits), .err(err), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        i_rd = 0; i_addr = 0; d_rd = 0; d_wr = 0; d_addr = 0; d_data_in = 0;
        m_data_out = 0; m_done = 0; m_stall = 0; m_cache_hit = 0; m_err = 0;
    endtask

    task automatic rst_dut();
        rst = 1'b0;
        clear_inputs();
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Completion monitor: every done pulse must match the head of the queue.
    always @(negedge clk) begin
        if (mon_en && rst && (i_done || d_done)) begin
            check("dual_done", 32'(i_done & d_done), 32'd0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_done: observed i_done=%b d_done=%b expected none", i_done, d_done);
            end else begin
                check("done_data", {15'd0, d_done, (d_done ? d_data_out : i_data_out)}, 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", state, 0);
        check("rst_err", err, 0);
        check("rst_i_hits", i_hits, 0);
        check("rst_d_hits", d_hits, 0);
        check("rst_m_rd", m_rd, 0);
        rst = 1'b1;

        // Fetch hit in the grant cycle
        @(posedge clk); #1;
        i_rd = 1; i_addr = 16'h0010; m_done = 1; m_cache_hit = 1; m_data_out = 16'h1234;
        exp_q.push_back({1'b0, 16'h1234});
        @(negedge clk);
        check("t1_m_rd", m_rd, 1);
        check("t1_m_addr", m_addr, 16'h0010);
        check("t1_i_done", i_done, 1);
        check("t1_i_stall", i_stall, 0);
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        check("t1_i_hits", i_hits, 1);
        check("t1_state", state, 0);

        // Store miss completing 12 cycles after grant
        @(posedge clk); #1;
        d_wr = 1; d_addr = 16'h0100; d_data_in = 16'hBEEF; m_data_out = 16'h5555;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            m_done = (k == 12);
            if (k == 12) exp_q.push_back({1'b1, 16'h5555});
            @(negedge clk);
            check("t2_m_wr", m_wr, 32'(k == 0));
            check("t2_d_stall", d_stall, 32'(k < 12));
            check("t2_d_done", d_done, 32'(k == 12));
            check("t2_m_addr", m_addr, 16'h0100);
            check("t2_m_data_in", m_data_in, 16'hBEEF);
        end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        check("t2_d_hits", d_hits, 0);
        check("t2_state", state, 0);

        // Both ports held: grants alternate D, I, D, I with 5-cycle misses
        rst_dut();
        @(posedge clk); #1;
        i_rd = 1; i_addr = 16'h0200; d_rd = 1; d_addr = 16'h0300;
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k <= 5; k++) begin
                logic port_d;
                port_d = (g % 2 == 0);
                if (!(g == 0 && k == 0)) begin @(posedge clk); #1; end
                m_done = (k == 5);
                m_data_out = 16'hA000 + 16'(g);
                if (k == 5) exp_q.push_back({port_d, 16'hA000 + 16'(g)});
                @(negedge clk);
                if (k == 0) begin
                    check("t3_grant_addr", m_addr, port_d ? 16'h0300 : 16'h0200);
                    check("t3_grant_rd", m_rd, 1);
                end else if (k < 5) begin
                    check("t3_busy_state", state, port_d ? 2 : 1);
                    check("t3_busy_rd", m_rd, 0);
                end
            end
        end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        check("t3_state", state, 0);

        // Data hit counter saturation
        rst_dut();
        mon_en = 1'b0;
        @(posedge clk); #1;
        d_rd = 1; d_addr = 16'hFFFE; m_done = 1; m_cache_hit = 1;
        repeat (65534) @(posedge clk);
        #1;
        clear_inputs();
        @(negedge clk);
        check("t4_d_hits_fffe", d_hits, 16'hFFFE);
        @(posedge clk); #1;
        d_rd = 1; d_addr = 16'hFFFE; m_done = 1; m_cache_hit = 1;
        repeat (3) @(posedge clk);
        #1;
        clear_inputs();
        @(negedge clk);
        check("t4_d_hits_sat", d_hits, 16'hFFFF);
        check("t4_i_hits", i_hits, 0);
        check("t4_err", err, 0);
        mon_en = 1'b1;

        // Hang timeout on a fetch access
        rst_dut();
        @(posedge clk); #1;
        i_rd = 1; i_addr = 16'h0050;
        for (int k = 0; k <= 70; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            check("t5_err", err, 32'(k >= 64));
        end
        #2 rst = 1'b0;
        #1;
        check("t5_err_cleared", err, 0);
        check("t5_i_stall", i_stall, 0);

        // Asynchronous reset in the middle of BUSY_D
        rst_dut();
        @(posedge clk); #1;
        d_rd = 1; d_addr = 16'h0400;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("t6_busy_d", state, 2);
        check("t6_d_stall", d_stall, 1);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_state", state, 0);
        check("t6_rst_d_stall", d_stall, 0);
        check("t6_rst_m_addr", m_addr, 0);
        check("t6_rst_err", err, 0);
        i_rd = 1; i_addr = 16'h0600;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_regrant_rd", m_rd, 1);
        check("t6_regrant_addr", m_addr, 16'h0400);
        @(posedge clk); #1;
        m_done = 1; m_data_out = 16'h7777;
        exp_q.push_back({1'b1, 16'h7777});
        @(negedge clk);
        check("t6_busy_after", state, 2);
        check("t6_d_done", d_done, 1);
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        check("t6_idle", state, 0);

        // Error sources: m_err, stray m_done, simultaneous load+store
        rst_dut();
        @(posedge clk); #1; m_err = 1;
        @(posedge clk); #1; m_err = 0;
        @(negedge clk);
        check("t7_m_err", err, 1);
        rst_dut();
        @(negedge clk);
        check("t7_err_clear", err, 0);
        @(posedge clk); #1; m_done = 1;
        @(posedge clk); #1; m_done = 0;
        @(negedge clk);
        check("t7_stray_done", err, 1);
        check("t7_stray_state", state, 0);
        rst_dut();
        @(posedge clk); #1;
        d_rd = 1; d_wr = 1; d_addr = 16'h0900; m_done = 1; m_data_out = 16'h4242;
        exp_q.push_back({1'b1, 16'h4242});
        @(negedge clk);
        check("t7_rw_m_rd", m_rd, 1);
        check("t7_rw_m_wr", m_wr, 1);
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        check("t7_rw_err", err, 1);

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
